max_unpooling_1: RTL and testbench
==================================

MAX_UNPOOLING_1 -- requirements
Module: max_unpooling_1

Interface
REQ-001 Parameters SHALL be: BITWIDTH, default 32, data word width; CHANNELS, default 2, feature-map channels; POOL_DIM, default 14, pooled map side.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  pooled entry present.
REQ-005 in_ready  output  1  block accepts pooled entry.
REQ-006 in_data  input  BITWIDTH  pooled max value.
REQ-007 in_idx  input  2  argmax position in 2x2 window: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right.
REQ-008 out_valid  output  1  output pixel present.
REQ-009 out_ready  input  1  consumer accepts pixel.
REQ-010 out_data  output  BITWIDTH  unpooled pixel value.
REQ-011 out_last  output  1  marks pixel (27,27) of each channel.
REQ-012 out_frame_last  output  1  marks pixel (27,27) of channel CHANNELS-1.

Function
REQ-013 Input order SHALL be channel-major, then pooled row, then pooled column; output order SHALL be channel-major over the 2*POOL_DIM x 2*POOL_DIM map, row-major.
REQ-014 Output pixel (2r+dy, 2c+dx) SHALL equal pooled value (r,c) when in_idx==2*dy+dx, else 0.
REQ-015 A transfer SHALL occur on any edge with valid && ready on that port; no other edge changes counters.
REQ-016 FSM states: FILL, EMIT_TOP, EMIT_BOT.
REQ-017 FILL: in_ready=1, out_valid=0; each accepted entry is stored at column counter position; after the POOL_DIM-th accept, next state is EMIT_TOP.
REQ-018 EMIT_TOP: out_valid=1, in_ready=0; emits 2*POOL_DIM pixels of row 2r (dy=0); after the last handshake, next state is EMIT_BOT.
REQ-019 EMIT_BOT: emits row 2r+1 (dy=1); after the last handshake, next state is FILL, pooled row counter increments, and wraps to 0 with channel increment after row POOL_DIM-1.
REQ-020 Channel counter SHALL wrap to 0 after CHANNELS-1; the next frame begins with no idle cycle.
REQ-021 Latency: the first out_valid SHALL appear the cycle after the POOL_DIM-th input handshake of a row.
REQ-022 No fill/emit overlap: in_ready SHALL be 0 throughout EMIT states.
REQ-023 While out_valid && !out_ready, out_data, out_last, and out_frame_last SHALL hold stable.
REQ-024 out_data, out_last, and out_frame_last SHALL be 0 whenever out_valid=0.
REQ-025 out_frame_last SHALL be asserted only together with out_last.

Reset
REQ-026 With rst_n=0 at a clock edge, state SHALL go to FILL and all counters SHALL clear to 0.
REQ-027 Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, out_frame_last=0.
REQ-028 Row buffer contents need not be reset; they SHALL never reach out_data before being rewritten.
REQ-029 Reset mid-row or mid-emit SHALL abandon the partial row; the first input after reset is pooled (0,0,0).

Structure
REQ-030 Shared package maxpool_pkg SHALL hold BITWIDTH, CHANNELS, POOL_DIM, FMAP_DIM=2*POOL_DIM, the argmax index encoding typedef, and the unpool FSM state enum.
REQ-031 One sub-module, unpool_row_buffer, SHALL hold POOL_DIM entries of {value, idx} with one write port and one combinational read port.
REQ-032 The row buffer SHALL be the only storage; the full frame SHALL NOT be buffered.

Verification
REQ-033 Reset, then channel 0 row 0 = {1145,idx3}, remaining entries {0,idx0}, out_ready=1 -> row0 all 0; row1 col1 = 1145, all other pixels 0.
REQ-034 Entries {5,idx0},{6,idx1},{7,idx2},{8,idx3} at columns 0-3 -> row0 = 5,0,0,6,0,0,0,0; row1 = 0,0,0,0,7,0,0,8.
REQ-035 During emit, drop out_ready for 3 cycles at pixel 10 -> out_data held; in_ready=0; no pixel skipped or duplicated.
REQ-036 Full frame of 2x14x14 random inputs, random in_valid/out_ready -> 1568 pixels match model; out_last on pixels 784 and 1568; out_frame_last only on pixel 1568.
REQ-037 Assert rst_n=0 after 7 accepted entries -> next cycle in_ready=1, out_valid=0; subsequent row output uses only post-reset data.
REQ-038 in_valid held high across an EMIT phase -> no input accepted until FILL; first out_valid appears exactly 1 cycle after the 14th accept.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared sizing, argmax encoding and unpool FSM state type for the max-unpooling block.
package maxpool_pkg;
  localparam int BITWIDTH = 32;
  localparam int CHANNELS = 2;
  localparam int POOL_DIM = 14;
  localparam int FMAP_DIM = 2 * POOL_DIM;

  // Position of the max inside a 2x2 window, {dy, dx}.
  typedef enum logic [1:0] {
    IDX_TL = 2'd0,
    IDX_TR = 2'd1,
    IDX_BL = 2'd2,
    IDX_BR = 2'd3
  } argmax_idx_t;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT_TOP = 2'd1,
    EMIT_BOT = 2'd2
  } unpool_state_t;

  // Counter width that never collapses to zero bits for trivial sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/unpool_row_buffer.sv
// One pooled row of {value, argmax index}: single write port, combinational read.
module unpool_row_buffer
  import maxpool_pkg::*;
#(
  parameter int WIDTH = BITWIDTH,
  parameter int DEPTH = POOL_DIM,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  argmax_idx_t      wr_idx,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output argmax_idx_t      rd_idx
);
  logic [WIDTH-1:0] val_mem [DEPTH];
  argmax_idx_t      idx_mem [DEPTH];

  // No reset: a row is always completely rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      val_mem[wr_addr] <= wr_data;
      idx_mem[wr_addr] <= wr_idx;
    end
  end

  assign rd_data = val_mem[rd_addr];
  assign rd_idx  = idx_mem[rd_addr];
endmodule

// File: rtl/max_unpooling_1.sv
// 2x2 max-unpooling: buffers one pooled row, then streams the two full-resolution rows it expands to.
module max_unpooling_1 #(
  parameter int BITWIDTH = maxpool_pkg::BITWIDTH,
  parameter int CHANNELS = maxpool_pkg::CHANNELS,
  parameter int POOL_DIM = maxpool_pkg::POOL_DIM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic [1:0]          in_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                out_last,
  output logic                out_frame_last
);
  import maxpool_pkg::*;

  // state    | meaning
  // FILL     | accepting one pooled row into the row buffer
  // EMIT_TOP | streaming full-res row 2r   (dy = 0)
  // EMIT_BOT | streaming full-res row 2r+1 (dy = 1)

  localparam int FMAP_SIDE = 2 * POOL_DIM;
  localparam int CW = cnt_width(POOL_DIM);
  localparam int PW = cnt_width(FMAP_SIDE);
  localparam int HW = cnt_width(CHANNELS);

  unpool_state_t state, state_nxt;
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] row_cnt;
  logic [PW-1:0] pix_cnt;
  logic [HW-1:0] ch_cnt;

  logic in_fire, out_fire, fill_done, row_done, map_done;
  logic [BITWIDTH-1:0] rd_data;
  argmax_idx_t rd_idx;
  logic [1:0] pos;

  assign in_ready  = (state == FILL);
  assign out_valid = (state != FILL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign fill_done = in_fire && (col_cnt == CW'(POOL_DIM - 1));
  assign row_done  = out_fire && (pix_cnt == PW'(FMAP_SIDE - 1));
  assign map_done  = (row_cnt == CW'(POOL_DIM - 1));

  unpool_row_buffer #(
    .WIDTH (BITWIDTH),
    .DEPTH (POOL_DIM)
  ) u_row_buffer (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_addr (col_cnt),
    .wr_data (in_data),
    .wr_idx  (argmax_idx_t'(in_idx)),
    .rd_addr (CW'(pix_cnt >> 1)),
    .rd_data (rd_data),
    .rd_idx  (rd_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    out_data       = '0;
    out_last       = 1'b0;
    out_frame_last = 1'b0;
    pos            = {state == EMIT_BOT, pix_cnt[0]};
    case (state)
      FILL:     if (fill_done) state_nxt = EMIT_TOP;
      EMIT_TOP: if (row_done)  state_nxt = EMIT_BOT;
      EMIT_BOT: begin
        out_last       = (pix_cnt == PW'(FMAP_SIDE - 1)) && map_done;
        out_frame_last = out_last && (ch_cnt == HW'(CHANNELS - 1));
        if (row_done) state_nxt = FILL;
      end
      default:  state_nxt = FILL;
    endcase
    // Outputs derive only from registered state, so they hold while stalled.
    if (out_valid && (rd_idx == argmax_idx_t'(pos))) out_data = rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      pix_cnt <= '0;
      ch_cnt  <= '0;
    end else begin
      if (in_fire)  col_cnt <= fill_done ? '0 : col_cnt + CW'(1);
      if (out_fire) pix_cnt <= row_done  ? '0 : pix_cnt + PW'(1);
      if (row_done && (state == EMIT_BOT)) begin
        row_cnt <= map_done ? '0 : row_cnt + CW'(1);
        if (map_done) ch_cnt <= (ch_cnt == HW'(CHANNELS - 1)) ? '0 : ch_cnt + HW'(1);
      end
    end
  end
endmodule

// File: tb/tb_max_unpooling_1.sv
// Self-checking bench for max_unpooling_1: directed table rows, stall/reset sequences and a random full frame.
module tb_max_unpooling_1;
  localparam int BW = 32;
  localparam int CH = 2;
  localparam int PD = 14;
  localparam int FD = 2 * PD;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_last, out_frame_last;
  logic [BW-1:0] in_data, out_data;
  logic [1:0] in_idx;

  always #5 clk = ~clk;

  max_unpooling_1 #(.BITWIDTH(BW), .CHANNELS(CH), .POOL_DIM(PD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_idx         (in_idx),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_frame_last (out_frame_last)
  );

  typedef struct { logic [31:0] v; logic [1:0] idx; } entry_t;
  typedef struct { logic [31:0] d; logic last; logic flast; } pix_t;
  typedef struct { logic [31:0] v; logic [1:0] idx; logic [31:0] tl, tr, bl, br; } vec_t;

  int total = 0;
  int bad   = 0;
  entry_t in_q[$];
  pix_t   exp_q[$];
  int trk_ch = 0;
  int trk_row = 0;
  entry_t row_buf[PD];
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_last(input int row, input int dy, input int x);
    return (row == PD - 1) && (dy == 1) && (x == FD - 1);
  endfunction

  // Queue one pooled row; optionally derive its 2 output rows from the unpooling definition.
  task automatic push_row(input bit gen_exp);
    pix_t p;
    for (int c = 0; c < PD; c++) in_q.push_back(row_buf[c]);
    if (gen_exp) begin
      for (int dy = 0; dy < 2; dy++) begin
        for (int x = 0; x < FD; x++) begin
          p.d     = (int'(row_buf[x/2].idx) == 2*dy + x%2) ? row_buf[x/2].v : 32'd0;
          p.last  = is_last(trk_row, dy, x);
          p.flast = p.last && (trk_ch == CH - 1);
          exp_q.push_back(p);
        end
      end
    end
    trk_row++;
    if (trk_row == PD) begin
      trk_row = 0;
      trk_ch  = (trk_ch + 1) % CH;
    end
  endtask

  task automatic rand_row();
    for (int c = 0; c < PD; c++) begin
      row_buf[c].v   = $urandom;
      row_buf[c].idx = 2'($urandom_range(3, 0));
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    trk_ch = 0;
    trk_row = 0;
    in_q.delete();
    exp_q.delete();
  endtask

  // Drive queued entries and score every output handshake; pv/pr are valid/ready percentages.
  task automatic run_stream(input int pv, input int pr, input int stall_at);
    int accepts = 0;
    int emitted = 0;
    int stall_left = 3;
    int budget = 20000;
    bit lat_chk = 0;
    bit held = 0;
    pix_t hold;
    pix_t e;
    while ((in_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (lat_chk) check("latency_out_valid", out_valid, 1'b1);
      lat_chk = 0;
      check("in_ready_vs_out_valid", in_ready, !out_valid);
      if (!out_valid) check("idle_outputs_zero", {out_data, out_last, out_frame_last}, 64'd0);
      if (out_frame_last) check("frame_last_implies_last", out_last, 1'b1);
      if (held) check("stall_hold", {out_data, out_last, out_frame_last}, {hold.d, hold.last, hold.flast});
      held = 0;

      in_valid = (in_q.size() > 0) && ($urandom_range(99, 0) < pv);
      if (in_valid) begin
        in_data = in_q[0].v;
        in_idx  = in_q[0].idx;
      end
      out_ready = ($urandom_range(99, 0) < pr);
      if (stall_at >= 0 && out_valid && emitted == stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end

      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        accepts++;
        if (accepts % PD == 0) lat_chk = 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pixel_data", out_data, e.d);
          check("pixel_last", out_last, e.last);
          check("pixel_frame_last", out_frame_last, e.flast);
        end
        emitted++;
      end else if (out_valid) begin
        held = 1;
        hold.d = out_data;
        hold.last = out_last;
        hold.flast = out_frame_last;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (budget == 0) begin
      check("stream_timeout", in_q.size() + exp_q.size(), 0);
      in_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    pix_t p;
    tbl[0] = '{32'd5, 2'd0, 32'd5, 32'd0, 32'd0, 32'd0};
    tbl[1] = '{32'd6, 2'd1, 32'd0, 32'd6, 32'd0, 32'd0};
    tbl[2] = '{32'd7, 2'd2, 32'd0, 32'd0, 32'd7, 32'd0};
    tbl[3] = '{32'd8, 2'd3, 32'd0, 32'd0, 32'd0, 32'd8};
    tbl[4] = '{32'hFFFF_FFFF, 2'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
    tbl[5] = '{32'h8000_0001, 2'd1, 32'd0, 32'h8000_0001, 32'd0, 32'd0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_out_frame_last", out_frame_last, 1'b0);
    do_reset();

    // Single max at bottom-right of window 0.
    for (int c = 0; c < PD; c++) row_buf[c] = '{32'd0, 2'd0};
    row_buf[0] = '{32'd1145, 2'd3};
    push_row(1);
    run_stream(100, 100, -1);

    // Table-driven row: expected pixels come from the hand-written table.
    for (int c = 0; c < PD; c++) row_buf[c] = '{32'd0, 2'd0};
    for (int i = 0; i < 6; i++) row_buf[i] = '{tbl[i].v, tbl[i].idx};
    push_row(0);
    for (int dy = 0; dy < 2; dy++) begin
      for (int c = 0; c < PD; c++) begin
        for (int dx = 0; dx < 2; dx++) begin
          p.d = 32'd0;
          if (c < 6) p.d = (dy == 0) ? ((dx == 0) ? tbl[c].tl : tbl[c].tr)
                                     : ((dx == 0) ? tbl[c].bl : tbl[c].br);
          p.last = 1'b0;
          p.flast = 1'b0;
          exp_q.push_back(p);
        end
      end
    end
    run_stream(100, 100, -1);

    // Consumer stall of 3 cycles at pixel 10.
    rand_row(); push_row(1);
    run_stream(100, 100, 10);

    // in_valid held high across emit phases.
    rand_row(); push_row(1);
    rand_row(); push_row(1);
    run_stream(100, 100, -1);
    rand_row(); push_row(1);
    rand_row(); push_row(1);
    run_stream(100, 60, -1);

    // Reset after 7 accepted entries abandons the partial row.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data = 32'hDEAD_0000 + 32'(i);
      in_idx = 2'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrow_reset_in_ready", in_ready, 1'b1);
    check("midrow_reset_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    rand_row(); push_row(1);
    run_stream(70, 70, -1);

    // Full random frame plus one row into the next frame.
    do_reset();
    for (int r = 0; r < CH * PD + 1; r++) begin
      rand_row();
      push_row(1);
    end
    run_stream(60, 60, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
